sha_msg_sched: RTL

- SHA-256 message-schedule generator for the bitcoin_miner datapath: producer side of the per-round W word consumed by the round logic.
- Accepts one 512-bit message block and streams W_0..W_63, one 32-bit word per accepted transfer, with a valid/ready handshake.
- Holds a 16-word sliding window internally; no 64-word storage.

---
 rtl/sha_msg_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule generator.
// Captures one 512-bit block and streams W_0..W_(NUM_ROUNDS-1) over a
// valid/ready handshake. A 16-word window holds W_t..W_(t+15). Each accepted
// word shifts the window by one and appends W_(t+16).
module sha_msg_sched #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [511:0] block_i,
  output logic         busy,
  output logic [31:0]  w_o,
  output logic [5:0]   t_o,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         done
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

  state_t      state_reg;
  logic [31:0] win_reg  [16];
  logic [31:0] win_next [16];
  logic        capture;
  logic        advance;
  logic [31:0] sched_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign capture = (state_reg == IDLE) && en;
  assign advance = (state_reg == RUN) && w_valid && w_ready;

  // win_reg[k] holds W_(t+k). This is the schedule word 16 positions past the current output.
  assign sched_next = sig1(win_reg[14]) + win_reg[9] + sig0(win_reg[1]) + win_reg[0];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_win
      if (gi < 15) begin : g_shift
        assign win_next[gi] = capture ? block_i[511-32*gi -: 32] :
                              advance ? win_reg[gi+1] : win_reg[gi];
      end else begin : g_tail
        assign win_next[gi] = capture ? block_i[31:0] :
                              advance ? sched_next : win_reg[gi];
      end
    end
  endgenerate

  // Window register: cleared on reset, otherwise follows the load/shift/hold mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) win_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_reg[i] <= win_next[i];
    end
  end

  // Control FSM with registered outputs. done is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      w_valid   <= 1'b0;
      done      <= 1'b0;
      w_o       <= '0;
      t_o       <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            w_o       <= block_i[511:480];
            t_o       <= '0;
            w_valid   <= 1'b1;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (w_valid && w_ready) begin
            if (t_o == T_LAST) begin
              w_valid   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= IDLE;
            end else begin
              t_o <= t_o + 6'd1;
              w_o <= win_reg[1];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
